// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM states, {cpol,cpha} modes, latched frame config.
// No logic here; latency and backpressure are properties of the importing modules.
package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int EDGE_CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } spi_state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef struct packed {
        logic lsbfe;
        logic cpol;
        logic cpha;
    } spi_cfg_t;

endpackage

// File: rtl/spi_sck_divider.sv
// Phase timer: one-cycle tick every div+1 cycles, counting from zero after restart drops.
// Latency: first tick div+1 cycles after restart deasserts; no backpressure.
module spi_sck_divider #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    // Counts only up to div, so an all-ones divisor never wraps.
    assign tick = !restart && (cnt_q == div);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (restart || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-frame SPI master, all four CPOL/CPHA modes, MSB/LSB first, programmable SCK half-period.
// Latency: start to done is H*(2*DATA_W+2)+1 cycles; start is dropped (not queued) unless IDLE.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              LSBFE,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              MISO,
    output logic              SS_b,
    output logic              SCK,
    output logic              MOSI,
    output logic [DATA_W-1:0] Data_out,
    output logic              busy,
    output logic              done
);

    localparam logic [EDGE_CNT_W-1:0] LAST_EDGE = EDGE_CNT_W'(2 * DATA_W - 1);

    spi_state_t              state_q, state_d;
    spi_cfg_t                cfg_q;
    logic [DIV_W-1:0]        div_q;
    logic [DATA_W-1:0]       tx_q;
    logic [DATA_W-1:0]       rx_q;
    logic [DATA_W-1:0]       data_out_q;
    logic [EDGE_CNT_W-1:0]   edge_q;
    logic                    sck_q, mosi_q, ss_b_q, busy_q, done_q;
    logic                    tick, div_restart;
    logic                    accept, toggle, lead_edge, trail_edge, advance, sample;

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    assign div_restart = (state_q == IDLE) || (state_q == DONE);

    spi_sck_divider #(.DIV_W(DIV_W)) u_div (
        .clk     (clk),
        .rst     (rst),
        .restart (div_restart),
        .div     (div_q),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        toggle  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: if (tick) state_d = XFER;
            XFER: begin
                if (tick) begin
                    toggle = 1'b1;
                    if (edge_q == LAST_EDGE) state_d = HOLD;
                end
            end
            HOLD:    if (tick) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Even edge count means the next toggle is a leading (odd-numbered) edge.
    assign lead_edge  = toggle && !edge_q[0];
    assign trail_edge = toggle &&  edge_q[0];
    assign advance    = cfg_q.cpha ? lead_edge : (trail_edge && (edge_q != LAST_EDGE));
    assign sample     = cfg_q.cpha ? trail_edge : lead_edge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_q      <= '0;
            div_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            edge_q     <= '0;
            mosi_q     <= 1'b0;
            data_out_q <= '0;
        end else if (accept) begin
            cfg_q  <= '{lsbfe: LSBFE, cpol: cpol, cpha: cpha};
            div_q  <= clk_div;
            rx_q   <= '0;
            edge_q <= '0;
            // cpha=0 must present the first bit before the first edge.
            if (cpha) begin
                tx_q   <= Data_in;
                mosi_q <= 1'b0;
            end else begin
                tx_q   <= shift_out(Data_in, LSBFE);
                mosi_q <= first_bit(Data_in, LSBFE);
            end
        end else begin
            if (advance) begin
                mosi_q <= first_bit(tx_q, cfg_q.lsbfe);
                tx_q   <= shift_out(tx_q, cfg_q.lsbfe);
            end
            if (sample) begin
                rx_q <= cfg_q.lsbfe ? {MISO, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], MISO};
            end
            if (toggle) begin
                edge_q <= edge_q + 1'b1;
            end
            if ((state_q == HOLD) && tick) begin
                mosi_q     <= 1'b0;
                data_out_q <= rx_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE:    sck_q <= cpol;
                XFER:    if (toggle) sck_q <= ~sck_q;
                default: sck_q <= cfg_q.cpol;
            endcase
        end
    end

    // Registered from next state so SS_b never glitches on state decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_b_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ss_b_q <= !((state_d == SETUP) || (state_d == XFER) || (state_d == HOLD));
            busy_q <=   (state_d == SETUP) || (state_d == XFER) || (state_d == HOLD);
            done_q <=   (state_d == DONE);
        end
    end

    assign SS_b     = ss_b_q;
    assign SCK      = sck_q;
    assign MOSI     = mosi_q;
    assign Data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Frame-vector bench for spi_master_ctrl with a behavioural SPI slave and a done-driven scoreboard.
`timescale 1ns/1ps
module tb_spi_master_ctrl;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] Data_in;
    logic       LSBFE, cpol, cpha;
    logic [7:0] clk_div;
    wire        MISO;
    logic       SS_b, SCK, MOSI, busy, done;
    logic [7:0] Data_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic       loop_en = 1'b0;
    logic       miso_s = 1'b0;
    logic       s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
    logic [7:0] s_data = 8'h00, s_sh = 8'h00, s_rx = 8'h00;

    assign MISO = loop_en ? MOSI : miso_s;

    spi_master_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Data_in  (Data_in),
        .LSBFE    (LSBFE),
        .cpol     (cpol),
        .cpha     (cpha),
        .clk_div  (clk_div),
        .MISO     (MISO),
        .SS_b     (SS_b),
        .SCK      (SCK),
        .MOSI     (MOSI),
        .Data_out (Data_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       cpol, cpha, lsb;
        logic [7:0] div, din, sdat;
        bit         loop;
        logic [7:0] exp_dout;
        int         exp_ss, exp_lat;
    } frame_t;

    typedef struct {
        logic [7:0] dout, srx;
        int         ss, lat, per, start_cyc;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    function automatic frame_t mk(input logic [1:0] mode, input logic lsb, input logic [7:0] div,
                                  input logic [7:0] din, input logic [7:0] sdat, input bit loop);
        frame_t f;
        f.cpol     = mode[1];
        f.cpha     = mode[0];
        f.lsb      = lsb;
        f.div      = div;
        f.din      = din;
        f.sdat     = sdat;
        f.loop     = loop;
        f.exp_dout = loop ? din : sdat;
        f.exp_ss   = (int'(div) + 1) * 18;
        f.exp_lat  = f.exp_ss + 1;
        return f;
    endfunction

    // Slave model: edges detected between negedges, so MOSI/SCK updates never race it.
    initial begin
        logic p_ss, p_sck, lead;
        p_ss = 1'b1;
        p_sck = 1'b0;
        forever begin
            @(negedge clk);
            if (p_ss && !SS_b) begin
                s_sh = s_data;
                s_rx = 8'h00;
                if (!s_cpha) begin
                    miso_s = s_lsb ? s_sh[0] : s_sh[7];
                    s_sh   = s_lsb ? (s_sh >> 1) : (s_sh << 1);
                end
            end else if (!SS_b && (SCK != p_sck)) begin
                lead = (SCK != s_cpol);
                if (lead != s_cpha) begin
                    s_rx = s_lsb ? {MOSI, s_rx[7:1]} : {s_rx[6:0], MOSI};
                end else begin
                    miso_s = s_lsb ? s_sh[0] : s_sh[7];
                    s_sh   = s_lsb ? (s_sh >> 1) : (s_sh << 1);
                end
            end
            p_ss  = SS_b;
            p_sck = SCK;
        end
    end

    // Frame monitor: measures SS_b width, SCK toggles and period, and pops the scoreboard on done.
    initial begin
        logic p_ss, p_sck;
        int   ss_cnt, togs, t1, t3;
        exp_t e;
        p_ss = 1'b1;
        p_sck = 1'b0;
        ss_cnt = 0;
        togs = 0;
        t1 = 0;
        t3 = 0;
        forever begin
            @(negedge clk);
            if (!SS_b) begin
                if (p_ss) begin
                    ss_cnt = 0;
                    togs = 0;
                    t1 = 0;
                    t3 = 0;
                end
                ss_cnt++;
                if (!p_ss && (SCK != p_sck)) begin
                    togs++;
                    if (togs == 1) t1 = cyc;
                    if (togs == 3) t3 = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("data_out",   Data_out, e.dout);
                    chk("slave_rx",   s_rx, e.srx);
                    chk("ss_low",     ss_cnt, e.ss);
                    chk("latency",    cyc - e.start_cyc, e.lat);
                    chk("sck_toggles", togs, 16);
                    chk("sck_period", t3 - t1, e.per);
                    chk("busy_at_done", busy, 1'b0);
                end
            end
            p_ss  = SS_b;
            p_sck = SCK;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setup_cfg(input frame_t v);
        cpol    = v.cpol;
        cpha    = v.cpha;
        LSBFE   = v.lsb;
        clk_div = v.div;
        Data_in = v.din;
        loop_en = v.loop;
        s_cpol  = v.cpol;
        s_cpha  = v.cpha;
        s_lsb   = v.lsb;
        s_data  = v.sdat;
    endtask

    task automatic launch(input frame_t v, input bit push);
        exp_t e;
        e.dout      = v.exp_dout;
        e.srx       = v.din;
        e.ss        = v.exp_ss;
        e.lat       = v.exp_lat;
        e.per       = 2 * (int'(v.div) + 1);
        e.start_cyc = cyc;
        if (push) sb_q.push_back(e);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_frame(input frame_t v, input bit disturb);
        int n;
        int budget;
        budget = v.exp_ss + 40;
        setup_cfg(v);
        repeat (2) step();
        launch(v, 1'b1);
        if (disturb) begin
            step();
            start   = 1'b1;
            cpol    = ~v.cpol;
            cpha    = ~v.cpha;
            LSBFE   = ~v.lsb;
            clk_div = 8'd5;
            Data_in = ~v.din;
            step();
            start = 1'b0;
            repeat (3) step();
            start = 1'b1;
            step();
            start = 1'b0;
        end
        n = 0;
        while ((sb_q.size() != 0) && (n < budget)) begin
            step();
            n++;
        end
        chk("frame_timeout", 32'(n < budget), 32'd1);
        sb_q.delete();
        repeat (3) step();
    endtask

    initial begin
        frame_t vecs[6];
        int     d0, n;

        vecs[0] = mk(MODE0, 1'b0, 8'd0,   8'hA5, 8'h00, 1'b1);
        vecs[1] = mk(MODE3, 1'b1, 8'd3,   8'h01, 8'h3C, 1'b0);
        vecs[2] = mk(MODE1, 1'b0, 8'd1,   8'h5A, 8'hC3, 1'b0);
        vecs[3] = mk(MODE2, 1'b1, 8'd2,   8'h5A, 8'hC3, 1'b0);
        vecs[4] = mk(MODE0, 1'b0, 8'd255, 8'h96, 8'h69, 1'b0);
        vecs[5] = mk(MODE1, 1'b1, 8'd0,   8'hC3, 8'h00, 1'b1);

        rst = 1'b0;
        start = 1'b0;
        Data_in = 8'h00;
        LSBFE = 1'b0;
        cpol = 1'b1;
        cpha = 1'b0;
        clk_div = 8'd0;
        repeat (3) step();
        chk("rst_ss_b", SS_b, 1'b1);
        chk("rst_sck", SCK, 1'b0);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_data_out", Data_out, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        cpol = 1'b0;
        rst = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], 1'b0);
        end

        // SCK tracks live cpol in IDLE, one cycle late
        step();
        cpol = 1'b1;
        chk("idle_sck_before_rise", SCK, 1'b0);
        step();
        chk("idle_sck_follow_rise", SCK, 1'b1);
        cpol = 1'b0;
        step();
        chk("idle_sck_follow_fall", SCK, 1'b0);
        step();

        // Restarts and config changes mid-frame: exactly one frame, unchanged waveform
        d0 = done_cnt;
        run_frame(mk(MODE0, 1'b0, 8'd0, 8'h3E, 8'h00, 1'b1), 1'b1);
        repeat (40) step();
        chk("single_done_pulse", done_cnt - d0, 1);

        // start during DONE is dropped
        setup_cfg(mk(MODE0, 1'b0, 8'd0, 8'hC6, 8'h39, 1'b0));
        repeat (2) step();
        d0 = done_cnt;
        launch(mk(MODE0, 1'b0, 8'd0, 8'hC6, 8'h39, 1'b0), 1'b1);
        n = 0;
        while (!done && (n < 40)) begin
            step();
            n++;
        end
        chk("done_reached", done, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_in_done_busy", busy, 1'b0);
        chk("start_in_done_ss_b", SS_b, 1'b1);
        repeat (30) step();
        chk("start_in_done_count", done_cnt - d0, 1);
        sb_q.delete();

        // Reset at the 5th SCK toggle of a frame
        setup_cfg(mk(MODE0, 1'b0, 8'd0, 8'h55, 8'h00, 1'b1));
        repeat (2) step();
        launch(mk(MODE0, 1'b0, 8'd0, 8'h55, 8'h00, 1'b1), 1'b0);
        repeat (6) step();
        chk("pre_rst_sck", SCK, 1'b1);
        d0 = done_cnt;
        rst = 1'b0;
        #1;
        chk("mid_rst_ss_b", SS_b, 1'b1);
        chk("mid_rst_sck", SCK, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_data_out", Data_out, 8'h00);
        repeat (3) step();
        rst = 1'b1;
        repeat (25) step();
        chk("mid_rst_no_done", done_cnt - d0, 0);
        run_frame(mk(MODE0, 1'b0, 8'd0, 8'hFF, 8'h00, 1'b1), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
